// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register with skid buffer: registered in_ready, full throughput,
// flush to a bubble value, and a saturating backpressure counter. State updates on falling clk.
module pipe_skid_reg #(
   parameter int                   PAYLOAD_W   = 64,
   parameter logic [PAYLOAD_W-1:0] FLUSH_VALUE = '0,
   parameter int                   CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   input  logic [PAYLOAD_W-1:0] in_data,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [PAYLOAD_W-1:0] out_data,
   input  logic                 out_ready,
   output logic [CNT_W-1:0]     stall_cnt
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   logic [1:0]           state;
   logic [PAYLOAD_W-1:0] main_q;
   logic [PAYLOAD_W-1:0] skid_q;
   logic                 accept;
   logic                 deliver;

   // Outputs decode straight from the state register, so in_ready has no path from inputs.
   assign out_valid = (state != EMPTY);
   assign in_ready  = (state != FULL);
   assign out_data  = main_q;

   assign accept  = in_valid && in_ready;
   assign deliver = out_valid && out_ready;

   // NOTE: non-blocking assignments keep every register sampling pre-edge values.
   always_ff @(negedge clk) begin
      if (reset) begin
         state     <= EMPTY;
         main_q    <= FLUSH_VALUE;
         skid_q    <= FLUSH_VALUE;
         stall_cnt <= '0;
      end else begin
         // Counter survives flush: it measures downstream backpressure, not pipeline contents.
         if (out_valid && !out_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;

         if (flush) begin
            state  <= EMPTY;
            main_q <= FLUSH_VALUE;
            skid_q <= FLUSH_VALUE;
         end else begin
            case (state)
               EMPTY: begin
                  if (accept) begin
                     state  <= ONE;
                     main_q <= in_data;
                  end
               end
               ONE: begin
                  if (accept && deliver) begin
                     main_q <= in_data;
                  end else if (accept) begin
                     state  <= FULL;
                     skid_q <= in_data;
                  end else if (deliver) begin
                     state <= EMPTY;
                  end
               end
               FULL: begin
                  if (deliver) begin
                     state  <= ONE;
                     main_q <= skid_q;
                  end
               end
               default: state <= EMPTY;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: a default instance plus a CNT_W=4 instance share stimulus;
// outputs are sampled 1 time unit after each falling edge.
module tb_pipe_skid_reg;

   localparam int          PW = 64;
   localparam logic [63:0] FV = 64'hDEAD_BEEF_0000_F1F1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic [PW-1:0] in_data = '0;
   logic          out_ready = 1'b0;

   logic          in_ready, out_valid;
   logic [PW-1:0] out_data;
   logic [15:0]   stall_cnt;

   logic          in_ready4, out_valid4;
   logic [PW-1:0] out_data4;
   logic [3:0]    stall_cnt4;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   pipe_skid_reg #(.PAYLOAD_W(PW), .FLUSH_VALUE(FV)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .stall_cnt(stall_cnt)
   );

   pipe_skid_reg #(.PAYLOAD_W(PW), .FLUSH_VALUE(FV), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready4), .out_valid(out_valid4), .out_data(out_data4),
      .out_ready(out_ready), .stall_cnt(stall_cnt4)
   );

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      compared++; if (out_data !== FV) begin mismatched++; $display("FAIL reset_out_data: got %h expected %h", out_data, FV); end
      compared++; if (stall_cnt !== 16'd0) begin mismatched++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt); end
      compared++; if (stall_cnt4 !== 4'd0) begin mismatched++; $display("FAIL reset_stall4: got %0d expected 0", stall_cnt4); end
   endtask

   task automatic test_streaming();
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1;
         in_data  = 64'(i);
         compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready); end
         tick();
         compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, out_valid); end
         compared++; if (out_data !== 64'(i)) begin mismatched++; $display("FAIL stream_data[%0d]: got %h expected %h", i, out_data, 64'(i)); end
      end
      in_valid = 1'b0;
      in_data  = 64'h1234;
      tick();
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL stream_drain_valid: got %b expected 0", out_valid); end
      compared++; if (out_data !== 64'h8) begin mismatched++; $display("FAIL stream_hold_data: got %h expected 8", out_data); end
      compared++; if (stall_cnt !== 16'd0) begin mismatched++; $display("FAIL stream_stall: got %0d expected 0", stall_cnt); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'hA;
      tick();
      compared++; if (out_data !== 64'hA) begin mismatched++; $display("FAIL bp_first_data: got %h expected a", out_data); end
      compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_one_ready: got %b expected 1", in_ready); end
      in_data = 64'hB;
      tick();
      compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_full_ready: got %b expected 0", in_ready); end
      compared++; if (out_data !== 64'hA) begin mismatched++; $display("FAIL bp_full_data: got %h expected a", out_data); end
      compared++; if (stall_cnt !== 16'd1) begin mismatched++; $display("FAIL bp_stall1: got %0d expected 1", stall_cnt); end
      in_data = 64'h77;
      tick();
      compared++; if (stall_cnt !== 16'd2) begin mismatched++; $display("FAIL bp_stall2: got %0d expected 2", stall_cnt); end
      compared++; if (out_data !== 64'hA) begin mismatched++; $display("FAIL bp_hold_data: got %h expected a", out_data); end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      compared++; if (out_data !== 64'hB) begin mismatched++; $display("FAIL bp_second_data: got %h expected b", out_data); end
      compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_second_valid: got %b expected 1", out_valid); end
      compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_ready_back: got %b expected 1", in_ready); end
      tick();
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_drained: got %b expected 0", out_valid); end
      compared++; if (stall_cnt4 !== 4'd2) begin mismatched++; $display("FAIL bp_stall4: got %0d expected 2", stall_cnt4); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'h11;
      tick();
      in_data = 64'h22;
      tick();
      compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL flush_prefull: got %b expected 0", in_ready); end
      compared++; if (stall_cnt !== 16'd3) begin mismatched++; $display("FAIL flush_prestall: got %0d expected 3", stall_cnt); end
      flush     = 1'b1;
      out_ready = 1'b1;
      in_data   = 64'hC;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
      compared++; if (out_data !== FV) begin mismatched++; $display("FAIL flush_data: got %h expected %h", out_data, FV); end
      compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL flush_ready: got %b expected 1", in_ready); end
      for (int i = 0; i < 3; i++) begin
         tick();
         compared++; if (out_valid !== 1'b0 || out_data !== FV) begin mismatched++; $display("FAIL flush_no_beat[%0d]: got %b/%h expected 0/%h", i, out_valid, out_data, FV); end
      end
      compared++; if (stall_cnt !== 16'd3) begin mismatched++; $display("FAIL flush_stall_kept: got %0d expected 3", stall_cnt); end
   endtask

   task automatic test_saturation();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'h44;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      compared++; if (stall_cnt4 !== 4'd15) begin mismatched++; $display("FAIL sat_stall4: got %0d expected 15", stall_cnt4); end
      compared++; if (stall_cnt !== 16'd23) begin mismatched++; $display("FAIL sat_stall16: got %0d expected 23", stall_cnt); end
      compared++; if (out_data !== 64'h44) begin mismatched++; $display("FAIL sat_data: got %h expected 44", out_data); end
      flush     = 1'b1;
      out_ready = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      compared++; if (stall_cnt4 !== 4'd15) begin mismatched++; $display("FAIL sat_after_flush4: got %0d expected 15", stall_cnt4); end
      compared++; if (stall_cnt !== 16'd23) begin mismatched++; $display("FAIL sat_after_flush16: got %0d expected 23", stall_cnt); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'h66;
      tick();
      compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL rmid_one: got %b expected 1", out_valid); end
      reset    = 1'b1;
      in_valid = 1'b0;
      tick();
      reset = 1'b0;
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rmid_valid: got %b expected 0", out_valid); end
      compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL rmid_ready: got %b expected 1", in_ready); end
      compared++; if (out_data !== FV) begin mismatched++; $display("FAIL rmid_data: got %h expected %h", out_data, FV); end
      compared++; if (stall_cnt !== 16'd0 || stall_cnt4 !== 4'd0) begin mismatched++; $display("FAIL rmid_stall: got %0d/%0d expected 0/0", stall_cnt, stall_cnt4); end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 64'h5;
      tick();
      in_valid = 1'b0;
      compared++; if (out_valid !== 1'b1 || out_data !== 64'h5) begin mismatched++; $display("FAIL rmid_new: got %b/%h expected 1/5", out_valid, out_data); end
      tick();
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rmid_alone: got %b expected 0", out_valid); end
      tick();
      compared++; if (out_valid !== 1'b0 || out_data !== 64'h5) begin mismatched++; $display("FAIL rmid_idle: got %b/%h expected 0/5", out_valid, out_data); end
   endtask

   initial begin
      @(posedge clk);
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_saturation();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Parameters
REQ-001 SHALL provide parameter PAYLOAD_W, default 64, meaning the payload width in bits (for example PC plus instruction).
REQ-002 SHALL provide parameter FLUSH_VALUE, default all-zero PAYLOAD_W, meaning the value driven on out_data after reset or flush (a NOP bubble).
REQ-003 SHALL provide parameter CNT_W, default 16, meaning the width of the stall counter.

Interface
REQ-004 clk  in  1  stage clock; all state updates on falling edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 flush  in  1  kill all held beats, insert bubble.
REQ-007 in_valid  in  1  upstream beat present.
REQ-008 in_data  in  PAYLOAD_W  upstream payload.
REQ-009 in_ready  out  1  stage can accept; registered, equals NOT skid_valid.
REQ-010 out_valid  out  1  downstream beat present.
REQ-011 out_data  out  PAYLOAD_W  downstream payload (main register).
REQ-012 out_ready  in  1  downstream consumes beat.
REQ-013 stall_cnt  out  CNT_W  saturating count of backpressure cycles.

Function
REQ-014 SHALL hold two entries, main (drives out_*) and skid; the occupancy state SHALL be EMPTY, ONE or FULL.
REQ-015 Accept SHALL occur on an edge with in_valid=1 and in_ready=1; deliver SHALL occur on an edge with out_valid=1 and out_ready=1.
REQ-016 EMPTY: accept -> ONE, main<=in_data; otherwise stay EMPTY.
REQ-017 ONE: accept and deliver -> ONE, main<=in_data; accept only -> FULL, skid<=in_data, main unchanged; deliver only -> EMPTY; neither -> ONE.
REQ-018 FULL: deliver -> ONE, main<=skid; otherwise FULL; no accept possible (in_ready=0).
REQ-019 Latency SHALL be one edge from accept to out_valid when main is free; sustained throughput SHALL be one beat per cycle with out_ready held 1.
REQ-020 Ordering SHALL be strict FIFO; no beat SHALL be duplicated or dropped except by flush.
REQ-021 out_data SHALL hold its last value while out_valid=0, except after reset or flush, when it SHALL be FLUSH_VALUE.
REQ-022 flush=1 SHALL force EMPTY on that edge, out_data<=FLUSH_VALUE, and skid cleared; any concurrent in_valid beat SHALL be discarded; in_ready=1 on the next cycle.
REQ-023 Priority SHALL be reset > flush > normal handshake.
REQ-024 stall_cnt SHALL increment on each edge with out_valid=1 and out_ready=0, saturate at 2^CNT_W-1, and not be cleared by flush.
REQ-025 in_data and out_ready changes while no handshake occurs SHALL have no effect on state.

Reset
REQ-026 On reset edge: state EMPTY, out_valid=0, in_ready=1, out_data=FLUSH_VALUE, skid=FLUSH_VALUE, stall_cnt=0.
REQ-027 Reset asserted mid-transfer SHALL discard both entries with no beat delivered afterward.

Verification
REQ-028 Streaming: out_ready=1, in_data=0x1..0x8 on consecutive cycles -> same eight values on out_data one edge later, out_valid continuous, in_ready always 1.
REQ-029 Backpressure: accept 0xA, 0xB with out_ready=0 -> FULL, in_ready=0, stall_cnt counts; raise out_ready -> 0xA then 0xB delivered, in_ready returns 1 after 0xA leaves.
REQ-030 Flush while FULL with concurrent in_valid=1 (in_data=0xC) -> next cycle out_valid=0, out_data=FLUSH_VALUE, in_ready=1, 0xC never appears.
REQ-031 Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and holds; a flush leaves it at 15.
REQ-032 Reset mid-stream in state ONE -> all outputs match REQ-026 on the next cycle; a new beat 0x5 accepted afterward is delivered alone.
